// File: rtl/seizure_pkg.sv
// Shared definitions for the seizure coefficient SRAM arbiter: widths, requester
// indices and return-tag bit positions.
package seizure_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 72;

    typedef enum logic [1:0] {
        REQ_PC   = 2'd0,
        REQ_DCTC = 2'd1,
        REQ_LUT  = 2'd2
    } req_idx_e;

    localparam int TAG_APB  = 0;
    localparam int TAG_PC   = 1;
    localparam int TAG_DCTC = 2;
    localparam int TAG_LUT  = 3;
    localparam int TAG_W    = 4;

    function automatic req_idx_e next_req(input req_idx_e idx);
        case (idx)
            REQ_PC:   return REQ_DCTC;
            REQ_DCTC: return REQ_LUT;
            default:  return REQ_PC;
        endcase
    endfunction

    function automatic logic [2:0] req_onehot(input req_idx_e idx);
        case (idx)
            REQ_PC:   return 3'b001;
            REQ_DCTC: return 3'b010;
            default:  return 3'b100;
        endcase
    endfunction

endpackage

// File: rtl/seizure_rr_arb.sv
// Three-way round-robin arbiter for the core read requesters. The pointer marks
// the highest-priority requester and advances past whichever one was granted.
module seizure_rr_arb
    import seizure_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       en,
    output logic [2:0] gnt
);

    req_idx_e ptr;
    req_idx_e ptr_next;
    req_idx_e cand0;
    req_idx_e cand1;
    req_idx_e cand2;

    always_comb begin
        cand0    = ptr;
        cand1    = next_req(cand0);
        cand2    = next_req(cand1);
        gnt      = 3'b000;
        ptr_next = ptr;
        if (en) begin
            if (|(req & req_onehot(cand0))) begin
                gnt      = req_onehot(cand0);
                ptr_next = cand1;
            end else if (|(req & req_onehot(cand1))) begin
                gnt      = req_onehot(cand1);
                ptr_next = cand2;
            end else if (|(req & req_onehot(cand2))) begin
                gnt      = req_onehot(cand2);
                ptr_next = next_req(cand2);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= REQ_PC;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/seizure_mem_arb.sv
// Shares the single-port coefficient SRAM between the APB host and the three
// core read requesters, with a bounded wait for the host while the core runs.
module seizure_mem_arb
    import seizure_pkg::*;
#(
    parameter int          ADDR_W     = ADDR_W_DEF,
    parameter int          DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = 15
) (
    input  logic                  apb_clk,
    input  logic                  reset_n,
    input  logic                  core_active,
    input  logic                  apb_req,
    input  logic                  apb_we,
    input  logic [ADDR_W-1:0]     apb_addr,
    input  logic [DATA_W-1:0]     apb_wdata,
    output logic                  apb_gnt,
    output logic                  apb_rvalid,
    input  logic [2:0]            core_req,
    input  logic [3*ADDR_W-1:0]   core_addr,
    output logic [2:0]            core_gnt,
    output logic [2:0]            core_rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0]       starve_cnt;
    logic             starve_hit;
    logic             rr_en;
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] tag_next;

    // Idle host always wins; a running core yields only when it has nothing
    // pending or the host has waited its full allowance.
    assign starve_hit = (starve_cnt == STARVE_LIM);
    assign apb_gnt    = apb_req & (~core_active | ~(|core_req) | starve_hit);
    assign rr_en      = ~apb_gnt;

    seizure_rr_arb u_rr (
        .clk   (apb_clk),
        .rst_n (reset_n),
        .req   (core_req),
        .en    (rr_en),
        .gnt   (core_gnt)
    );

    assign mem_en = apb_gnt | (|core_gnt);
    assign mem_we = apb_gnt & apb_we;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (apb_gnt) begin
            mem_addr  = apb_addr;
            mem_wdata = apb_wdata;
        end else if (core_gnt[REQ_PC]) begin
            mem_addr = core_addr[0*ADDR_W +: ADDR_W];
        end else if (core_gnt[REQ_DCTC]) begin
            mem_addr = core_addr[1*ADDR_W +: ADDR_W];
        end else if (core_gnt[REQ_LUT]) begin
            mem_addr = core_addr[2*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge apb_clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= 8'd0;
        end else if (!core_active || apb_gnt) begin
            starve_cnt <= 8'd0;
        end else if (apb_req && !starve_hit) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    // The tag remembers which requester owns next cycle's SRAM read data.
    always_comb begin
        tag_next           = '0;
        tag_next[TAG_APB]  = apb_gnt & ~apb_we;
        tag_next[TAG_PC]   = core_gnt[REQ_PC];
        tag_next[TAG_DCTC] = core_gnt[REQ_DCTC];
        tag_next[TAG_LUT]  = core_gnt[REQ_LUT];
    end

    always_ff @(posedge apb_clk or negedge reset_n) begin
        if (!reset_n) begin
            tag <= '0;
        end else begin
            tag <= tag_next;
        end
    end

    assign apb_rvalid  = tag[TAG_APB];
    assign core_rvalid = {tag[TAG_LUT], tag[TAG_DCTC], tag[TAG_PC]};
    assign rdata       = mem_rdata;

endmodule
